pwmmod_burst_seq: RTL and testbench
===================================

Name: pwmmod_burst_seq

Overview:
Sequencer that drives a carrier-modulated output as a series of mark/space bursts, for IR or laser style modulation.
- Accepts one burst command per valid/ready handshake: mark length, space length and repeat count.
- Gates an internal carrier generator, which has the same divider/duty semantics as the team's pwmmod.
- Sits between a register or command interface and the output pin.

Parameters:
MARK_WIDTH, 16, width of mark length in clk cycles
SPACE_WIDTH, 16, width of space length in clk cycles
REPEAT_WIDTH, 8, width of mark/space pair count
DIVIDER_FREQ, 10, carrier period in clk cycles (>=2)
DIVIDER_DTY, 3, carrier high cycles per period (1..DIVIDER_FREQ-1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command
cmd_mark  in  MARK_WIDTH  mark length in clk cycles
cmd_space  in  SPACE_WIDTH  space length in clk cycles
cmd_repeat  in  REPEAT_WIDTH  number of mark/space pairs
abort  in  1  synchronous cancel of running burst
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst end
aborted  out  1  qualifies done: burst ended by abort
gate  out  1  modulation enable (mark active)
dout  out  1  modulated output = gate AND carrier

Behaviour:
- Reset, asynchronous: state IDLE, all counters 0.
  - Outputs at reset: cmd_ready=1, busy=0, done=0, aborted=0, gate=0, dout=0.
  - Reset mid-burst forces gate/dout low immediately, with no wait for a clock edge.
- States: IDLE, MARK, SPACE.
- cmd_ready = (state==IDLE). A command is accepted on a clk edge with cmd_valid & cmd_ready.
  - On accept, mark, space and repeat are latched; later input changes have no effect.
  - cmd_valid while busy is ignored; no queueing.
- Accept with cmd_repeat==0: stay IDLE; done=1, aborted=0 on the next cycle; gate never rises.
- Accept with cmd_repeat>0:
  - Enter MARK, or SPACE if mark==0. The first gate-high cycle is the cycle after accept.
  - MARK lasts exactly mark cycles with gate=1, then SPACE.
  - SPACE lasts exactly space cycles with gate=0.
  - If space==0, the next MARK follows the previous MARK directly; gate stays high continuously.
  - A pair with mark==0 and space==0 takes 1 cycle.
- Pair counter decrements at the end of each SPACE.
  - After the last pair, state returns to IDLE and done pulses 1 cycle (aborted=0).
  - cmd_ready is 1 in the done cycle, so a new command may be accepted in that cycle.
- busy = (state!=IDLE).
- abort while busy:
  - Next cycle: state IDLE, gate=0, done=1, aborted=1.
  - If abort and the natural end coincide, abort wins and aborted=1.
  - abort in IDLE is ignored, including in the accept cycle; the command is still accepted.
- aborted is valid only while done=1, and is 0 otherwise.
- Carrier generation:
  - Counter runs 0..DIVIDER_FREQ-1 and wraps to 0.
  - carrier = (cnt < DIVIDER_DTY).
  - Counter is held at 0 outside MARK and restarts at 0 on every MARK entry, including back-to-back marks. Every mark therefore begins with DIVIDER_DTY high cycles.
- dout = gate & carrier, registered together with gate, so both change on the same edge.
- Mark/space counters are down-counters loaded with length-1. Full-width values are legal: a mark of 0xFFFF lasts 65535 cycles.

Decomposition:
- Shared package: state enum (IDLE/MARK/SPACE) and the lengths/count struct typedef parameterised by the widths.
- One sub-module: pwmmod_carrier.
  - Counter plus duty compare, with a sync-restart input.
  - Parameters DIVIDER_FREQ and DIVIDER_DTY.
  - Reusable by the plain pwmmod.

Test Plan (all with defaults DIVIDER_FREQ=10, DIVIDER_DTY=3; accept at cycle 0):
- mark=20, space=5, repeat=2 -> expected response:
  - gate=1 in cycles 1-20 and 26-45, gate=0 in cycles 21-25 and 46-50.
  - done=1, aborted=0 at cycle 51.
  - dout high in cycles 1-3, 11-13, 26-28, 36-38 (6 high cycles per mark).
- repeat=0 -> done=1 at cycle 1, busy never 1, gate/dout stay 0; a new command offered at cycle 1 is accepted.
- mark=7, space=0, repeat=3 -> gate=1 continuously in cycles 1-21; carrier restarts at cycles 8 and 15 (dout high 1-3, 8-10, 15-17); done at cycle 22.
- mark=0, space=4, repeat=2 -> gate never 1; done at cycle 9.
- mark=100, space=10, repeat=5, abort at cycle 30 -> gate=0 from cycle 31; done=1, aborted=1 at cycle 31; cmd_ready=1 at cycle 31. Second cmd_valid held during cycles 2-29 is not accepted.
- mark=50, repeat=1, rst asserted mid-mark (between edges at cycle 10) -> gate, dout, busy drop to 0 combinationally with rst; no done pulse; cmd_ready=1 after rst deasserts.

Source files
------------

// File: rtl/pwmmod_burst_seq_pkg.sv
// Shared types for the burst sequencer and its carrier.
// Holds the sequencer state encoding and default field widths.
package pwmmod_burst_seq_pkg;

    localparam int DEF_MARK_WIDTH   = 16;
    localparam int DEF_SPACE_WIDTH  = 16;
    localparam int DEF_REPEAT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE
    } burst_state_e;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pwmmod_burst_seq_if.sv
// Burst command channel: one mark/space/repeat command per valid/ready beat.
interface pwmmod_burst_seq_if #(
    parameter int MARK_WIDTH   = 16,
    parameter int SPACE_WIDTH  = 16,
    parameter int REPEAT_WIDTH = 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [MARK_WIDTH-1:0]   cmd_mark;
    logic [SPACE_WIDTH-1:0]  cmd_space;
    logic [REPEAT_WIDTH-1:0] cmd_repeat;

    modport master (
        output cmd_valid, cmd_mark, cmd_space, cmd_repeat,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_mark, cmd_space, cmd_repeat,
        output cmd_ready
    );
endinterface

// File: rtl/pwmmod_burst_seq_carrier.sv
// Carrier divider with duty compare and synchronous restart.
// The carrier output reflects the phase that will be live next cycle.
module pwmmod_carrier #(
    parameter int DIVIDER_FREQ = 10,
    parameter int DIVIDER_DTY  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic carrier
);
    localparam int CW = $clog2(DIVIDER_FREQ);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    always_comb begin
        cnt_n = '0;
        if (run && !restart) begin
            if (cnt == CW'(DIVIDER_FREQ - 1))
                cnt_n = '0;
            else
                cnt_n = cnt + CW'(1);
        end
    end

    // Callers register this alongside their own gate so both share an edge.
    assign carrier = (cnt_n < CW'(DIVIDER_DTY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= cnt_n;
    end
endmodule

// File: rtl/pwmmod_burst_seq.sv
// Mark/space burst sequencer gating a carrier onto a single output pin.
module pwmmod_burst_seq
    import pwmmod_burst_seq_pkg::*;
#(
    parameter int MARK_WIDTH   = DEF_MARK_WIDTH,
    parameter int SPACE_WIDTH  = DEF_SPACE_WIDTH,
    parameter int REPEAT_WIDTH = DEF_REPEAT_WIDTH,
    parameter int DIVIDER_FREQ = 10,
    parameter int DIVIDER_DTY  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    pwmmod_burst_seq_if.slave    cmd,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 gate,
    output logic                 dout
);
    localparam int LW = max_width(MARK_WIDTH, SPACE_WIDTH);

    typedef struct packed {
        logic [MARK_WIDTH-1:0]   mark;
        logic [SPACE_WIDTH-1:0]  space;
        logic [REPEAT_WIDTH-1:0] count;
    } burst_cmd_t;

    burst_state_e state, state_n;
    burst_cmd_t   cfg, cfg_n;
    logic [LW-1:0] len, len_n;
    logic done_n, aborted_n;
    logic pair_end, start_pair, restart;
    logic carrier;
    logic gate_q, dout_q, done_q, aborted_q;

    always_comb begin
        state_n    = state;
        cfg_n      = cfg;
        len_n      = len;
        done_n     = 1'b0;
        aborted_n  = 1'b0;
        pair_end   = 1'b0;
        start_pair = 1'b0;
        restart    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    cfg_n.mark  = cmd.cmd_mark;
                    cfg_n.space = cmd.cmd_space;
                    cfg_n.count = cmd.cmd_repeat;
                    if (cmd.cmd_repeat == '0)
                        done_n = 1'b1;
                    else
                        start_pair = 1'b1;
                end
            end
            MARK: begin
                if (len != '0) begin
                    len_n = len - LW'(1);
                end else if (cfg.space != '0) begin
                    state_n = SPACE;
                    len_n   = LW'(cfg.space - SPACE_WIDTH'(1));
                end else begin
                    pair_end = 1'b1;
                end
            end
            SPACE: begin
                if (len != '0)
                    len_n = len - LW'(1);
                else
                    pair_end = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (pair_end) begin
            if (cfg.count == REPEAT_WIDTH'(1)) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end else begin
                cfg_n.count = cfg.count - REPEAT_WIDTH'(1);
                start_pair  = 1'b1;
            end
        end

        // A zero-length mark still yields at least one space cycle per pair.
        if (start_pair) begin
            if (cfg_n.mark != '0) begin
                state_n = MARK;
                len_n   = LW'(cfg_n.mark - MARK_WIDTH'(1));
                restart = 1'b1;
            end else begin
                state_n = SPACE;
                len_n   = (cfg_n.space == '0) ? '0
                        : LW'(cfg_n.space - SPACE_WIDTH'(1));
            end
        end

        if (abort && state != IDLE) begin
            state_n   = IDLE;
            done_n    = 1'b1;
            aborted_n = 1'b1;
            restart   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cfg       <= '0;
            len       <= '0;
            gate_q    <= 1'b0;
            dout_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_n;
            cfg       <= cfg_n;
            len       <= len_n;
            gate_q    <= (state_n == MARK);
            dout_q    <= (state_n == MARK) && carrier;
            done_q    <= done_n;
            aborted_q <= aborted_n;
        end
    end

    pwmmod_carrier #(
        .DIVIDER_FREQ(DIVIDER_FREQ),
        .DIVIDER_DTY (DIVIDER_DTY)
    ) u_carrier (
        .clk    (clk),
        .rst    (rst),
        .run    (state_n == MARK),
        .restart(restart),
        .carrier(carrier)
    );

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign gate          = gate_q;
    assign dout          = dout_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
endmodule

// File: tb/tb_pwmmod_burst_seq.sv
// Bench for pwmmod_burst_seq: timeline model of bursts, directed plus random.
module tb_pwmmod_burst_seq;
    localparam int F = 10;
    localparam int D = 3;
    localparam int HN = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort_s = 1'b0;
    logic busy, done, aborted, gate, dout;

    pwmmod_burst_seq_if #(16, 16, 8) cmd_if ();

    pwmmod_burst_seq #(
        .MARK_WIDTH  (16),
        .SPACE_WIDTH (16),
        .REPEAT_WIDTH(8),
        .DIVIDER_FREQ(F),
        .DIVIDER_DTY (D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd    (cmd_if),
        .abort  (abort_s),
        .busy   (busy),
        .done   (done),
        .aborted(aborted),
        .gate   (gate),
        .dout   (dout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: last accepted burst, its timeline window and pending done.
    int t0 = -1;
    int burst_end = 0;
    int done_cyc = -1;
    bit ab_flag = 1'b0;
    int m_m = 0;
    int m_s = 0;

    bit hb[HN], hg[HN], hd[HN], hdn[HN], hab[HN], hr[HN];

    function automatic bit exp_busy(input int n);
        return (n > t0) && (n < burst_end);
    endfunction

    function automatic int period();
        return (m_m + m_s > 0) ? (m_m + m_s) : 1;
    endfunction

    function automatic bit exp_gate(input int n);
        if (!exp_busy(n))
            return 1'b0;
        return ((n - t0 - 1) % period()) < m_m;
    endfunction

    function automatic bit exp_dout(input int n);
        int pos;
        if (!exp_gate(n))
            return 1'b0;
        pos = (n - t0 - 1) % period();
        return (pos % F) < D;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b want %b", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit v, input int m, input int s,
                        input int r, input bit ab);
        @(negedge clk);
        chk("cmd_ready", cmd_if.cmd_ready, !exp_busy(cyc));
        chk("busy", busy, exp_busy(cyc));
        chk("gate", gate, exp_gate(cyc));
        chk("dout", dout, exp_dout(cyc));
        chk("done", done, cyc == done_cyc);
        chk("aborted", aborted, (cyc == done_cyc) && ab_flag);
        if (cyc < HN) begin
            hb[cyc]  = busy;
            hg[cyc]  = gate;
            hd[cyc]  = dout;
            hdn[cyc] = done;
            hab[cyc] = aborted;
            hr[cyc]  = cmd_if.cmd_ready;
        end
        cmd_if.cmd_valid  = v;
        cmd_if.cmd_mark   = 16'(m);
        cmd_if.cmd_space  = 16'(s);
        cmd_if.cmd_repeat = 8'(r);
        abort_s = ab;
        if (exp_busy(cyc)) begin
            if (ab) begin
                burst_end = cyc + 1;
                done_cyc  = cyc + 1;
                ab_flag   = 1'b1;
            end
        end else if (v) begin
            t0  = cyc;
            m_m = m;
            m_s = s;
            burst_end = cyc + 1 + r * period();
            done_cyc  = burst_end;
            ab_flag   = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic lit(input string name, input bit act, input bit exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    initial begin
        int c0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_mark   = '0;
        cmd_if.cmd_space  = '0;
        cmd_if.cmd_repeat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // mark=20 space=5 repeat=2
        c0 = cyc;
        step(1'b1, 20, 5, 2, 1'b0);
        idle(56);
        lit("t1 gate@1", hg[c0+1], 1'b1);
        lit("t1 gate@20", hg[c0+20], 1'b1);
        lit("t1 gate@21", hg[c0+21], 1'b0);
        lit("t1 gate@26", hg[c0+26], 1'b1);
        lit("t1 gate@46", hg[c0+46], 1'b0);
        lit("t1 dout@3", hd[c0+3], 1'b1);
        lit("t1 dout@4", hd[c0+4], 1'b0);
        lit("t1 dout@11", hd[c0+11], 1'b1);
        lit("t1 dout@36", hd[c0+36], 1'b1);
        lit("t1 done@50", hdn[c0+50], 1'b0);
        lit("t1 done@51", hdn[c0+51], 1'b1);
        lit("t1 aborted@51", hab[c0+51], 1'b0);

        // repeat=0, then a command taken in the done cycle
        c0 = cyc;
        step(1'b1, 9, 9, 0, 1'b0);
        step(1'b1, 3, 2, 1, 1'b0);
        idle(8);
        lit("t2 done@1", hdn[c0+1], 1'b1);
        lit("t2 busy@1", hb[c0+1], 1'b0);
        lit("t2 ready@1", hr[c0+1], 1'b1);
        lit("t2 busy@2", hb[c0+2], 1'b1);
        lit("t2 gate@2", hg[c0+2], 1'b1);

        // mark=7 space=0 repeat=3
        c0 = cyc;
        step(1'b1, 7, 0, 3, 1'b0);
        idle(25);
        lit("t3 gate@7", hg[c0+7], 1'b1);
        lit("t3 gate@8", hg[c0+8], 1'b1);
        lit("t3 dout@7", hd[c0+7], 1'b0);
        lit("t3 dout@8", hd[c0+8], 1'b1);
        lit("t3 dout@15", hd[c0+15], 1'b1);
        lit("t3 gate@21", hg[c0+21], 1'b1);
        lit("t3 done@22", hdn[c0+22], 1'b1);
        lit("t3 gate@22", hg[c0+22], 1'b0);

        // mark=0 space=4 repeat=2
        c0 = cyc;
        step(1'b1, 0, 4, 2, 1'b0);
        idle(11);
        lit("t4 busy@1", hb[c0+1], 1'b1);
        lit("t4 gate@1", hg[c0+1], 1'b0);
        lit("t4 done@8", hdn[c0+8], 1'b0);
        lit("t4 done@9", hdn[c0+9], 1'b1);

        // abort at cycle 30, valid held meanwhile
        c0 = cyc;
        step(1'b1, 100, 10, 5, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0);
        for (int k = 2; k < 30; k++)
            step(1'b1, 3, 3, 1, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1);
        idle(4);
        lit("t5 gate@30", hg[c0+30], 1'b1);
        lit("t5 gate@31", hg[c0+31], 1'b0);
        lit("t5 done@31", hdn[c0+31], 1'b1);
        lit("t5 aborted@31", hab[c0+31], 1'b1);
        lit("t5 ready@31", hr[c0+31], 1'b1);
        lit("t5 busy@32", hb[c0+32], 1'b0);

        // reset mid-mark
        step(1'b1, 50, 0, 1, 1'b0);
        idle(10);
        @(posedge clk);
        #2;
        lit("t6 gate pre-rst", gate, 1'b1);
        rst = 1'b1;
        #1;
        lit("t6 gate in rst", gate, 1'b0);
        lit("t6 dout in rst", dout, 1'b0);
        lit("t6 busy in rst", busy, 1'b0);
        lit("t6 ready in rst", cmd_if.cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t0 = -1;
        burst_end = 0;
        done_cyc = -1;
        idle(3);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            bit v, ab;
            int m, s, r;
            v  = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 39) == 0);
            m  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 40))
                                             : int'($urandom_range(0, 9));
            s  = int'($urandom_range(0, 6));
            r  = int'($urandom_range(0, 3));
            step(v, m, s, r, ab);
        end
        idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
